// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared FSM encoding and ADC frame constants for the RED ADC reader
package adc_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT     = 3'd1,
      CS_SETUP = 3'd2,
      SHIFT    = 3'd3,
      DONE     = 3'd4
   } adc_state_t;

   // One null bit followed by D7..D0.
   localparam int         FRAME_BITS = 9;
   localparam logic [3:0] NULL_BIT   = 4'd0;
   localparam logic [3:0] LAST_BIT   = 4'(FRAME_BITS - 1);

endpackage

// File: rtl/adc_sclk_gen.sv
// rtl/adc_sclk_gen.sv - ADC serial clock generator: half-period counter plus SCLK flop
module adc_sclk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic sclk,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

   logic [3:0] half_cnt;
   logic       wrap;

   // Pulses flag the cycle whose closing edge toggles SCLK.
   assign wrap       = run && (half_cnt == DIV_LAST);
   assign rise_pulse = wrap && !sclk;
   assign fall_pulse = wrap && sclk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         half_cnt <= 4'd0;
         sclk     <= 1'b0;
      end else if (!run) begin
         half_cnt <= 4'd0;
         sclk     <= 1'b0;
      end else if (wrap) begin
         half_cnt <= 4'd0;
         sclk     <= !sclk;
      end else begin
         half_cnt <= half_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/adc_red_reader.sv
// rtl/adc_red_reader.sv - periodic serial ADC reader producing 8-bit RED samples with a valid strobe
module adc_red_reader
   import adc_pkg::*;
#(
   parameter int CLK_DIV       = 2,
   parameter int SAMPLE_PERIOD = 64
) (
   input  logic       CLK_ADC,
   input  logic       rst,
   input  logic       en,
   input  logic       ADC_DOUT,
   output logic       ADC_CS_n,
   output logic       ADC_SCLK,
   output logic [7:0] RED_ADC_Value,
   output logic       RED_Valid,
   output logic       busy
);

   localparam logic [15:0] PER_LAST = 16'(SAMPLE_PERIOD - 1);

   adc_state_t  state, next_state;
   logic        en_q, dout_q;
   logic        run, sample_en, cs_n_d;
   logic        rise_pulse, fall_pulse;
   logic [3:0]  bit_cnt;
   logic [7:0]  shreg, shreg_nxt;
   logic [15:0] period_cnt;

   assign run       = (state == CS_SETUP) || (state == SHIFT);
   assign RED_Valid = (state == DONE);
   assign busy      = run || RED_Valid;

   adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
      .clk        (CLK_ADC),
      .rst        (rst),
      .run        (run),
      .sclk       (ADC_SCLK),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
   );

   always_ff @(posedge CLK_ADC or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (en_q) next_state = CS_SETUP;
         WAIT: begin
            if (!en_q)                        next_state = IDLE;
            else if (period_cnt == PER_LAST)  next_state = CS_SETUP;
         end
         CS_SETUP: if (rise_pulse) next_state = SHIFT;
         SHIFT:    if (fall_pulse && (bit_cnt == LAST_BIT)) next_state = DONE;
         DONE:     next_state = en_q ? WAIT : IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Sample is taken in the first SCLK-high cycle, when dout_q already holds the bit.
   always_comb begin
      cs_n_d    = !((next_state == CS_SETUP) || (next_state == SHIFT));
      shreg_nxt = shreg;
      if (sample_en && (bit_cnt != NULL_BIT)) shreg_nxt = {shreg[6:0], dout_q};
   end

   always_ff @(posedge CLK_ADC or posedge rst) begin
      if (rst) begin
         en_q          <= 1'b0;
         dout_q        <= 1'b0;
         ADC_CS_n      <= 1'b1;
         sample_en     <= 1'b0;
         bit_cnt       <= 4'd0;
         shreg         <= 8'd0;
         period_cnt    <= 16'd0;
         RED_ADC_Value <= 8'd0;
      end else begin
         en_q      <= en;
         dout_q    <= ADC_DOUT;
         ADC_CS_n  <= cs_n_d;
         sample_en <= rise_pulse;
         shreg     <= shreg_nxt;
         if (!run)
            bit_cnt <= 4'd0;
         else if (fall_pulse && (bit_cnt != LAST_BIT))
            bit_cnt <= bit_cnt + 4'd1;
         // Counter reads 0 at every T0 so the next frame lands exactly SAMPLE_PERIOD later.
         if ((state == IDLE) || (next_state == IDLE) || (period_cnt == PER_LAST))
            period_cnt <= 16'd0;
         else
            period_cnt <= period_cnt + 16'd1;
         if (next_state == DONE) RED_ADC_Value <= shreg_nxt;
      end
   end

endmodule

// File: tb/tb_adc_red_reader.sv
// tb/tb_adc_red_reader.sv - scoreboard bench for adc_red_reader at two clock-divider settings
module tb_adc_red_reader;

   typedef struct packed {
      logic [7:0] value;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic [1:0] rst = 2'b11;
   logic [1:0] en  = 2'b00;
   logic [1:0] dout = 2'b00;
   logic [1:0] cs_n, sclk, valid, busy;
   logic [7:0] value [2];

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   exp_t       exp_valid [2][$];
   int         exp_fall  [2][$];
   logic [7:0] model_q   [2][$];

   logic [1:0] prev_cs = 2'b11;
   logic [1:0] prev_sclk = 2'b00;
   logic [7:0] prev_val [2];
   logic [8:0] frame [2];
   int         bitpos [2];
   int         rise_cnt [2];
   int         rise_cyc [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   adc_red_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(64)) dut0 (
      .CLK_ADC(clk), .rst(rst[0]), .en(en[0]), .ADC_DOUT(dout[0]),
      .ADC_CS_n(cs_n[0]), .ADC_SCLK(sclk[0]), .RED_ADC_Value(value[0]),
      .RED_Valid(valid[0]), .busy(busy[0]));

   adc_red_reader #(.CLK_DIV(1), .SAMPLE_PERIOD(20)) dut1 (
      .CLK_ADC(clk), .rst(rst[1]), .en(en[1]), .ADC_DOUT(dout[1]),
      .ADC_CS_n(cs_n[1]), .ADC_SCLK(sclk[1]), .RED_ADC_Value(value[1]),
      .RED_Valid(valid[1]), .busy(busy[1]));

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // ADC model plus scoreboard monitor, one lane per DUT.
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         if (prev_cs[i] && !cs_n[i]) begin
            if (exp_fall[i].size() == 0) check($sformatf("unexpected_cs_fall_l%0d", i), cyc, -1);
            else check($sformatf("cs_fall_cycle_l%0d", i), cyc, exp_fall[i].pop_front());
            frame[i] = {1'b1, 8'h00};
            if (model_q[i].size() != 0) frame[i][7:0] = model_q[i].pop_front();
            bitpos[i]   = 0;
            rise_cnt[i] = 0;
         end
         if (!prev_cs[i] && cs_n[i]) rise_cyc[i] = cyc;
         if (!prev_sclk[i] && sclk[i]) rise_cnt[i]++;
         if (prev_sclk[i] && !sclk[i] && bitpos[i] < 8) bitpos[i]++;
         dout[i] = cs_n[i] ? 1'b0 : frame[i][8 - bitpos[i]];
         if (valid[i]) begin
            if (exp_valid[i].size() == 0) begin
               check($sformatf("unexpected_valid_l%0d", i), cyc, -1);
            end else begin
               e = exp_valid[i].pop_front();
               check($sformatf("value_l%0d", i), value[i], e.value);
               check($sformatf("valid_cycle_l%0d", i), cyc, e.cyc);
            end
            check($sformatf("sclk_pulses_l%0d", i), rise_cnt[i], 9);
            check($sformatf("cs_rise_cycle_l%0d", i), rise_cyc[i], cyc);
         end else if (!rst[i]) begin
            check($sformatf("value_hold_l%0d", i), value[i], prev_val[i]);
         end
         prev_cs[i]   = cs_n[i];
         prev_sclk[i] = sclk[i];
         prev_val[i]  = value[i];
      end
   end

   initial begin
      int t0, t1, bad;
      @(posedge clk);
      #2;
      goto(3);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset_cs_n_l%0d", i), cs_n[i], 1);
         check($sformatf("reset_sclk_l%0d", i), sclk[i], 0);
         check($sformatf("reset_value_l%0d", i), value[i], 0);
         check($sformatf("reset_valid_l%0d", i), valid[i], 0);
         check($sformatf("reset_busy_l%0d", i), busy[i], 0);
      end

      // Three back-to-back frames: A5, 00, FF.
      t0 = cyc + 2;
      model_q[0].push_back(8'hA5);
      model_q[0].push_back(8'h00);
      model_q[0].push_back(8'hFF);
      exp_fall[0].push_back(t0);
      exp_fall[0].push_back(t0 + 64);
      exp_fall[0].push_back(t0 + 128);
      exp_valid[0].push_back('{value: 8'hA5, cyc: t0 + 36});
      exp_valid[0].push_back('{value: 8'h00, cyc: t0 + 100});
      exp_valid[0].push_back('{value: 8'hFF, cyc: t0 + 164});
      en[0]  = 1'b1;
      rst[0] = 1'b0;
      goto(t0);
      check("cs_low_at_t0", cs_n[0], 0);
      check("busy_at_t0", busy[0], 1);
      goto(t0 + 35);
      check("cs_low_at_t0p35", cs_n[0], 0);
      goto(t0 + 36);
      check("busy_at_done", busy[0], 1);
      goto(t0 + 37);
      check("cs_high_after_done", cs_n[0], 1);
      check("busy_low_after_done", busy[0], 0);
      goto(t0 + 170);
      en[0] = 1'b0;
      goto(t0 + 200);

      // Disabled: no activity for 200 cycles.
      bad = 0;
      for (int k = 0; k < 200; k++) begin
         goto(cyc + 1);
         if (cs_n[0] !== 1'b1 || sclk[0] !== 1'b0 || valid[0] !== 1'b0) bad++;
      end
      check("idle_200_cycles", bad, 0);

      // en drops mid-frame: frame completes, then IDLE.
      t0 = cyc + 2;
      model_q[0].push_back(8'h3C);
      exp_fall[0].push_back(t0);
      exp_valid[0].push_back('{value: 8'h3C, cyc: t0 + 36});
      en[0] = 1'b1;
      goto(t0 + 10);
      en[0] = 1'b0;
      goto(t0 + 80);
      check("idle_after_drop_busy", busy[0], 0);
      check("idle_after_drop_cs", cs_n[0], 1);

      // Reset mid-frame aborts it; restart two cycles after release.
      t0 = cyc + 2;
      model_q[0].push_back(8'h5A);
      model_q[0].push_back(8'h96);
      exp_fall[0].push_back(t0);
      en[0] = 1'b1;
      goto(t0 + 20);
      rst[0] = 1'b1;
      #1;
      check("rst_cs_n", cs_n[0], 1);
      check("rst_sclk", sclk[0], 0);
      check("rst_value", value[0], 0);
      check("rst_busy", busy[0], 0);
      goto(t0 + 23);
      t1 = t0 + 25;
      exp_fall[0].push_back(t1);
      exp_valid[0].push_back('{value: 8'h96, cyc: t1 + 36});
      rst[0] = 1'b0;
      goto(t1);
      check("cs_low_after_rst", cs_n[0], 0);
      goto(t1 + 40);
      en[0] = 1'b0;
      goto(t1 + 80);

      // Minimum legal period with CLK_DIV=1.
      t0 = cyc + 2;
      model_q[1].push_back(8'h81);
      model_q[1].push_back(8'h81);
      exp_fall[1].push_back(t0);
      exp_fall[1].push_back(t0 + 20);
      exp_valid[1].push_back('{value: 8'h81, cyc: t0 + 18});
      exp_valid[1].push_back('{value: 8'h81, cyc: t0 + 38});
      en[1]  = 1'b1;
      rst[1] = 1'b0;
      goto(t0 + 25);
      en[1] = 1'b0;
      goto(t0 + 60);

      for (int i = 0; i < 2; i++) begin
         check($sformatf("missing_valid_l%0d", i), exp_valid[i].size(), 0);
         check($sformatf("missing_cs_fall_l%0d", i), exp_fall[i].size(), 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_red_reader.md
ADC_RED_READER -- requirements
Module: adc_red_reader

Interface
REQ-001 Parameter CLK_DIV, default 2, means CLK_ADC cycles per ADC_SCLK half-period; legal range 1..15.
REQ-002 Parameter SAMPLE_PERIOD, default 64, means CLK_ADC cycles between successive ADC_CS_n falling edges; legal range is 18*CLK_DIV+2 to 65535.
REQ-003 CLK_ADC  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  conversion enable, sampled each CLK_ADC cycle.
REQ-006 ADC_DOUT  input  1  serial data from the external ADC, MSB first; the block registers it before use.
REQ-007 ADC_CS_n  output  1  ADC chip select, active low.
REQ-008 ADC_SCLK  output  1  ADC serial clock, idle low.
REQ-009 RED_ADC_Value  output  8  last completed sample, fed to the RED FIR filter input.
REQ-010 RED_Valid  output  1  one-cycle strobe that marks a new RED_ADC_Value.
REQ-011 busy  output  1  high from the ADC_CS_n fall through the RED_Valid cycle, inclusive.

Function
REQ-012 The FSM shall have states IDLE, WAIT, CS_SETUP, SHIFT and DONE.
REQ-013 IDLE: ADC_CS_n=1, ADC_SCLK=0, period counter held at 0; if en=1 the FSM shall go to CS_SETUP on the next cycle.
REQ-014 Call the first CS_SETUP cycle T0; ADC_CS_n shall be 0 from T0 until the DONE cycle.
REQ-015 Rising edges of ADC_SCLK, k=0..8, shall occur at T0+CLK_DIV*(2k+1); falling edges shall occur at T0+CLK_DIV*(2k+2).
REQ-016 On each rising edge the registered ADC_DOUT shall be captured; bit k=0 is the ADC null bit and shall be discarded; bits k=1..8 are D7..D0 and shall be shifted into an 8-bit register.
REQ-017 DONE is at cycle T0+18*CLK_DIV and lasts one cycle: ADC_CS_n=1, RED_ADC_Value is updated with the shift register, RED_Valid=1.
REQ-018 RED_ADC_Value shall hold its value between DONE cycles and shall never change while RED_Valid=0.
REQ-019 After DONE: if en=1, go to WAIT; the next T0 shall be at T0+SAMPLE_PERIOD, counted by a 16-bit period counter that starts at T0. If en=0, go to IDLE.
REQ-020 While in WAIT, if en drops the FSM shall go to IDLE on the next cycle, and no partial frame shall occur.
REQ-021 If en drops during CS_SETUP or SHIFT, the frame shall complete normally, including RED_Valid; the FSM then goes to IDLE.
REQ-022 The period counter shall wrap to 0 at SAMPLE_PERIOD-1; the equation T0+SAMPLE_PERIOD shall hold exactly for every back-to-back frame.
REQ-023 The ADC_SCLK half-period counter shall wrap at CLK_DIV-1; the bit counter shall be 4 bits and count 0..8; no SCLK edge shall be generated after the falling edge of k=8.
REQ-024 ADC_CS_n and ADC_SCLK shall be driven directly from flops, with no combinational glitches.

Reset
REQ-025 While rst=1: FSM=IDLE, ADC_CS_n=1, ADC_SCLK=0, RED_ADC_Value=0, RED_Valid=0, busy=0, and all counters and the shift register are 0.
REQ-026 Reset asserted mid-frame shall abort the frame immediately (asynchronously), and no RED_Valid shall be produced for it.
REQ-027 After rst deasserts with en=1, the first T0 shall be 2 cycles later (one input-sync cycle plus IDLE).

Structure
REQ-028 The shared package adc_pkg shall hold the FSM state encoding, the ADC frame length constant (9 bits) and the null-bit index.
REQ-029 One sub-module, adc_sclk_gen, is natural: it holds the half-period counter plus the SCLK flop, with outputs rise_pulse and fall_pulse; everything else is in the top.

Verification
REQ-030 Use CLK_DIV=2, SAMPLE_PERIOD=64, en=1, and a bench ADC model that drives null bit 1 then 0xA5. Required: RED_ADC_Value=8'hA5 and RED_Valid high exactly at T0+36, ADC_CS_n low for cycles T0..T0+35, and 9 SCLK pulses.
REQ-031 Use back-to-back frames with model data 0x00 then 0xFF. Required: RED_Valid at T0+36 and T0+100, values 0x00 then 0xFF, and second ADC_CS_n fall at T0+64.
REQ-032 Hold en=0 for 200 cycles. Required: ADC_CS_n stays 1, ADC_SCLK stays 0, and RED_Valid stays 0.
REQ-033 Drop en at T0+10 with model data 0x3C. Required: the frame completes, RED_ADC_Value=8'h3C at T0+36, and the FSM is in IDLE with no CS_n fall at T0+64.
REQ-034 Assert rst at T0+20 for 3 cycles. Required: ADC_CS_n=1 and ADC_SCLK=0 within the same cycle, RED_ADC_Value=0, no RED_Valid, and a new T0 2 cycles after rst deasserts.
REQ-035 Use CLK_DIV=1, SAMPLE_PERIOD=20 (minimum legal) with data 0x81. Required: RED_Valid at T0+18, next T0 at T0+20, and value 8'h81 each frame.
